// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment BCD feeder and its refresh scanner.
package sseg_pkg;

  typedef logic [3:0] nibble_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_t;

  localparam nibble_t ADD3_THRESH = 4'd5;

  // Double-dabble correction: a digit of 5..9 gets +3 so the next shift carries into the next digit.
  function automatic nibble_t add3(input nibble_t n);
    return (n >= ADD3_THRESH) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/sseg_refresh_scanner.sv
// Refresh counter and digit index for the multiplexed display, producing a one-hot digit_sel.
// Macro LEADING_ZERO_BLANK_EN darkens leading-zero digit slots (digit 0 always lit).
module sseg_refresh_scanner
  import sseg_pkg::*;
#(
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 50000,
  parameter int IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  nibble_t [DIGITS-1:0]    digits,
  output logic    [IDX_W-1:0]     idx,
  output logic    [DIGITS-1:0]    digit_sel
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic [CNT_W-1:0]  cnt;
  logic [DIGITS-1:0] upper_zero;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
      cnt <= '0;
      idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // upper_zero[i]: digits i..DIGITS-1 are all zero.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    logic z;
    upper_zero = '0;
    z          = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      z             = z && (digits[i] == 4'd0);
      upper_zero[i] = z;
    end
  end

  always_comb begin
    digit_sel      = '0;
    digit_sel[idx] = 1'b1;
    if (BLANK_EN && (idx != '0) && upper_zero[idx]) digit_sel = '0;
  end

endmodule

// File: rtl/sseg_bin2bcd_scan.sv
// Binary-to-BCD converter (iterative double-dabble) with display latch and scanned digit output.
// Macro LEADING_ZERO_BLANK_EN (in sseg_refresh_scanner) blanks leading-zero digits.
module sseg_bin2bcd_scan
  import sseg_pkg::*;
#(
  parameter int BIN_W       = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BIN_W-1:0]  bin_in,
  input  logic              bin_valid,
  output logic              bin_ready,
  output logic              busy,
  output logic [3:0]        bcd_out,
  output logic [DIGITS-1:0] digit_sel
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SC_W  = $clog2(BIN_W + 1);

  if ((10 ** DIGITS) - 1 < (2 ** BIN_W) - 1) begin : g_range_check
    $error("sseg_bin2bcd_scan: DIGITS too small to hold 2**BIN_W-1");
  end

  state_t                   state;
  logic    [BIN_W-1:0]      shreg;
  logic    [SC_W-1:0]       scnt;
  nibble_t [DIGITS-1:0]     acc;
  nibble_t [DIGITS-1:0]     acc_adj;
  nibble_t [DIGITS-1:0]     disp;
  logic    [IDX_W-1:0]      idx;

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < DIGITS; i++) acc_adj[i] = add3(acc[i]);
  end

  // NOTE: the display latch is reset along with the FSM because it feeds the scan output directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bin_ready <= 1'b0;
      busy      <= 1'b0;
      shreg     <= '0;
      scnt      <= '0;
      acc       <= '0;
      disp      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bin_valid && bin_ready) begin
            shreg     <= bin_in;
            acc       <= '0;
            scnt      <= SC_W'(BIN_W);
            state     <= SHIFT;
            bin_ready <= 1'b0;
            busy      <= 1'b1;
          end else begin
            bin_ready <= 1'b1;
          end
        end
        SHIFT: begin
          {acc, shreg} <= {acc_adj, shreg} << 1;
          scnt         <= scnt - 1'b1;
          if (scnt == SC_W'(1)) state <= LOAD;
        end
        LOAD: begin
          disp      <= acc;
          state     <= IDLE;
          busy      <= 1'b0;
          bin_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sseg_refresh_scanner #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .IDX_W       (IDX_W)
  ) u_scanner (
    .clk       (clk),
    .reset     (reset),
    .digits    (disp),
    .idx       (idx),
    .digit_sel (digit_sel)
  );

  assign bcd_out = disp[idx];

endmodule

// File: tb/tb_sseg_bin2bcd_scan.sv
// Directed + random bench for sseg_bin2bcd_scan with a scoreboard of expected BCD values.
module tb_sseg_bin2bcd_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] bin_in;
  logic       bin_valid;
  logic       bin_ready;
  logic       busy;
  logic [3:0] bcd_out;
  logic [2:0] digit_sel;

  int checks = 0;
  int errors = 0;

  logic [11:0] q[$];
  logic [11:0] m_latch = '0;
  int          m_cnt   = 0;
  int          m_idx   = 0;

  always #5 clk = ~clk;

  sseg_bin2bcd_scan #(
    .BIN_W       (8),
    .DIGITS      (3),
    .REFRESH_DIV (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bin_in    (bin_in),
    .bin_valid (bin_valid),
    .bin_ready (bin_ready),
    .busy      (busy),
    .bcd_out   (bcd_out),
    .digit_sel (digit_sel)
  );

  // Reference scan position: each digit held 4 cycles, 3 digits.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt <= 0;
      m_idx <= 0;
    end else if (m_cnt == 3) begin
      m_cnt <= 0;
      m_idx <= (m_idx == 2) ? 0 : m_idx + 1;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  function automatic logic [11:0] to_bcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [2:0] exp_sel(input int idx, input logic [11:0] l);
    logic [2:0] s;
    s = 3'b001 << idx;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && (l >> (idx * 4)) == 12'd0) s = 3'b000;
`endif
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_disp();
    logic [11:0] l;
    l = m_latch;
    check("bcd_out", {28'd0, bcd_out}, {28'd0, 4'(l >> (m_idx * 4))});
    check("digit_sel", {29'd0, digit_sel}, {29'd0, exp_sel(m_idx, l)});
  endtask

  task automatic check_scan(input int n);
    for (int i = 0; i < n; i++) begin
      check_disp();
      check("idle_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
    end
  endtask

  // Handshake one value; returns at the negedge just after the accepting edge.
  task automatic start(input int v, input bit hold);
    int w;
    q.push_back(to_bcd(v));
    bin_in    = 8'(v);
    bin_valid = 1'b1;
    w = 0;
    while (bin_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", {31'd0, bin_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) bin_valid = 1'b0;
    check("busy_after_hs", {31'd0, busy}, 32'd1);
    check("ready_after_hs", {31'd0, bin_ready}, 32'd0);
  endtask

  task automatic finish_conv(input int exp_busy, input int scan_n);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      check_disp();
      @(negedge clk);
      n++;
    end
    check("busy_len", n, exp_busy);
    check("ready_back", {31'd0, bin_ready}, 32'd1);
    check("sb_nonempty", {31'd0, (q.size() > 0)}, 32'd1);
    if (q.size() > 0) m_latch = q.pop_front();
    check_scan(scan_n);
  endtask

  initial begin
    reset     = 1'b1;
    bin_valid = 1'b0;
    bin_in    = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, bin_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sel", {29'd0, digit_sel}, 32'd1);
    check("rst_bcd", {28'd0, bcd_out}, 32'd0);
    reset = 1'b0;
    check("ready_before_edge", {31'd0, bin_ready}, 32'd0);
    @(negedge clk);
    check("ready_after_edge", {31'd0, bin_ready}, 32'd1);

    start(255, 1'b0);
    finish_conv(9, 24);

    start(7, 1'b0);
    finish_conv(9, 12);

    // Back-to-back with bin_valid held: 100 must wait for bin_ready.
    start(0, 1'b1);
    bin_in = 8'd100;
    finish_conv(9, 0);
    start(100, 1'b0);
    finish_conv(9, 12);

    // Reset during the fourth SHIFT cycle of 200.
    start(200, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    q.delete();
    m_latch = '0;
    #1;
    check("midrst_ready", {31'd0, bin_ready}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_sel", {29'd0, digit_sel}, 32'd1);
    check("midrst_bcd", {28'd0, bcd_out}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("midrst_ready_rel", {31'd0, bin_ready}, 32'd0);
    @(negedge clk);
    check("midrst_ready_up", {31'd0, bin_ready}, 32'd1);
    check_scan(12);
    start(42, 1'b0);
    finish_conv(9, 12);

    // bin_valid pulsed while busy is ignored.
    start(33, 1'b0);
    bin_in    = 8'd99;
    bin_valid = 1'b1;
    check_disp();
    @(negedge clk);
    bin_valid = 1'b0;
    finish_conv(8, 12);

    for (int i = 0; i < 20; i++) begin
      start(int'($urandom_range(0, 255)), 1'b0);
      finish_conv(9, 12);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
